// File: rtl/fft8_stream_adapter.sv
// fft8_stream_adapter
//
// Streaming wrapper around the combinational fft8 core.
//   - Gathers eight serial complex samples (IEEE-754 single, real/imag) into
//     a parallel frame presented on fft_A_r/fft_A_i.
//   - Drives the constant 8-point twiddle set on fft_W_r/fft_W_i.
//   - Waits COMB_CYCLES cycles for the core to settle.
//   - Captures fft_C_r/fft_C_i and fft_EX.
//   - Replays the eight results serially with their bin index.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input sample handshake, in_r/in_i sample payload
//   fft_A_r/fft_A_i     : frame to the core, element k = k-th sample received
//   fft_W_r/fft_W_i     : constant twiddles W[0..3]
//   fft_C_r/fft_C_i     : core results, fft_EX core exception flag
//   out_valid/out_ready : result handshake
//   out_r/out_i         : result payload
//   out_idx             : bin index of the current result
//   out_last            : marks bin 7
//   out_ex              : exception flag captured with this frame
module fft8_stream_adapter #(
  parameter int unsigned COMB_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_r,
  input  logic [31:0]      in_i,
  output logic [7:0][31:0] fft_A_r,
  output logic [7:0][31:0] fft_A_i,
  output logic [3:0][31:0] fft_W_r,
  output logic [3:0][31:0] fft_W_i,
  input  logic [7:0][31:0] fft_C_r,
  input  logic [7:0][31:0] fft_C_i,
  input  logic             fft_EX,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [31:0]      out_i,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic             out_ex
);

  // Last settle count value before capture; COMB_CYCLES is 1..15 so it fits.
  localparam logic [3:0] SETTLE_LAST = 4'(COMB_CYCLES - 1);

  // Twiddles e^{-j*2*pi*k/8}, k = 0..3, element 0 in the low word.
  localparam logic [3:0][31:0] W_R = {32'hBF3504F3, 32'h00000000,
                                      32'h3F3504F3, 32'h3F800000};
  localparam logic [3:0][31:0] W_I = {32'hBF3504F3, 32'hBF800000,
                                      32'hBF3504F3, 32'h00000000};

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t          state_q,      state_d;
  logic [2:0]      wr_cnt_q,     wr_cnt_d;
  logic [3:0]      settle_cnt_q, settle_cnt_d;
  logic [2:0]      rd_cnt_q,     rd_cnt_d;
  logic [7:0][31:0] a_r_q,   a_r_d;
  logic [7:0][31:0] a_i_q,   a_i_d;
  logic [7:0][31:0] res_r_q, res_r_d;
  logic [7:0][31:0] res_i_q, res_i_d;
  logic            ex_q,         ex_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_twiddle
    assign fft_W_r[gi] = W_R[gi];
    assign fft_W_i[gi] = W_I[gi];
  end

  // The frame registers feed the core directly so it sees a stable frame
  // from the eighth accept until the next frame starts loading.
  assign fft_A_r = a_r_q;
  assign fft_A_i = a_i_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= '0;
      settle_cnt_q <= '0;
      rd_cnt_q     <= '0;
      a_r_q        <= '0;
      a_i_q        <= '0;
      res_r_q      <= '0;
      res_i_q      <= '0;
      ex_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      a_r_q        <= a_r_d;
      a_i_q        <= a_i_d;
      res_r_q      <= res_r_d;
      res_i_q      <= res_i_d;
      ex_q         <= ex_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    settle_cnt_d = settle_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    a_r_d        = a_r_q;
    a_i_d        = a_i_q;
    res_r_d      = res_r_q;
    res_i_d      = res_i_q;
    ex_d         = ex_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready) begin
          a_r_d[wr_cnt_q] = in_r;
          a_i_d[wr_cnt_q] = in_i;
          // 3-bit counter wraps to 0 on the eighth sample.
          wr_cnt_d        = wr_cnt_q + 3'd1;
          if (wr_cnt_q == 3'd7) begin
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q + 4'd1;
        if (settle_cnt_q == SETTLE_LAST) begin
          res_r_d  = fft_C_r;
          res_i_d  = fft_C_i;
          ex_d     = fft_EX;
          rd_cnt_d = '0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready) begin
          rd_cnt_d = rd_cnt_q + 3'd1;
          if (rd_cnt_q == 3'd7) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_DRAIN);
    out_last  = (state_q == ST_DRAIN) && (rd_cnt_q == 3'd7);
    out_idx   = rd_cnt_q;
    out_r     = res_r_q[rd_cnt_q];
    out_i     = res_i_q[rd_cnt_q];
    out_ex    = ex_q;
  end

endmodule

// File: tb/tb_fft8_stream_adapter.sv
// Bench for fft8_stream_adapter: two instances (COMB_CYCLES = 1 and 3), each
// wrapped around a behavioural 8-point DFT standing in for the fft8 core.
module tb_fft8_stream_adapter;

  logic clk;
  logic rst_n;

  logic            in_valid  [2];
  logic            in_ready  [2];
  logic [31:0]     in_r      [2];
  logic [31:0]     in_i      [2];
  logic [7:0][31:0] a_r      [2];
  logic [7:0][31:0] a_i      [2];
  logic [3:0][31:0] w_r      [2];
  logic [3:0][31:0] w_i      [2];
  logic            out_valid [2];
  logic            out_ready [2];
  logic [31:0]     out_r     [2];
  logic [31:0]     out_i     [2];
  logic [2:0]      out_idx   [2];
  logic            out_last  [2];
  logic            out_ex    [2];

  int vectors;
  int miscompares;

  logic [31:0]      frame_r [8];
  logic [31:0]      frame_i [8];
  logic [31:0]      got_r   [8];
  logic [31:0]      got_i   [8];
  logic [2:0]       got_idx [8];
  logic             got_last[8];
  logic             got_ex  [8];
  int               n_got, lat, cycles, hold_err, early_err;
  bit               timeout, ready_after;
  logic [7:0][31:0] exp_r_p, exp_i_p;
  logic             exp_ex;
  logic [5:0]       bp_pat;

  // ---------------- float <-> real helpers and core model ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'h00)      b = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) b = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int          e;
    logic [24:0] m;
    b = $realtobits(r);
    if (b[62:52] == 11'h7FF) return {b[63], 8'hFF, (b[51:0] != 0) ? {1'b1, b[50:29]} : 23'd0};
    if (b[62:52] == 11'h000) return {b[63], 31'd0};
    e = int'(b[62:52]) - 1023 + 127;
    m = {2'b01, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    if (e <= 0)   return {b[63], 31'd0};
    return {b[63], e[7:0], m[22:0]};
  endfunction

  // X[k] = sum_n x[n] * e^{-j*2*pi*n*k/8}; EX flags any Inf/NaN input.
  function automatic void fft_model(input logic [7:0][31:0] ar, input logic [7:0][31:0] ai,
                                    output logic [7:0][31:0] cr, output logic [7:0][31:0] ci,
                                    output logic ex);
    real ct [8];
    real st [8];
    real rt, re, im, xr, xi;
    int  m;
    rt = 0.7071067811865476;
    ct[0] = 1.0; ct[1] = rt;  ct[2] = 0.0; ct[3] = -rt; ct[4] = -1.0; ct[5] = -rt; ct[6] = 0.0;  ct[7] = rt;
    st[0] = 0.0; st[1] = rt;  st[2] = 1.0; st[3] = rt;  st[4] = 0.0;  st[5] = -rt; st[6] = -1.0; st[7] = -rt;
    ex = 1'b0;
    for (int n = 0; n < 8; n++)
      if (ar[n][30:23] == 8'hFF || ai[n][30:23] == 8'hFF) ex = 1'b1;
    for (int k = 0; k < 8; k++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 8; n++) begin
        m  = (n * k) % 8;
        xr = f2r(ar[n]);
        xi = f2r(ai[n]);
        re = re + (xr * ct[m] + xi * st[m]);
        im = im + (xi * ct[m] - xr * st[m]);
      end
      cr[k] = r2f(re);
      ci[k] = r2f(im);
    end
  endfunction

  // ---------------- DUTs ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [7:0][31:0] c_r_w, c_i_w;
    logic             ex_w;
    always_comb fft_model(a_r[gi], a_i[gi], c_r_w, c_i_w, ex_w);
    fft8_stream_adapter #(.COMB_CYCLES(gi == 0 ? 1 : 3)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .in_r     (in_r[gi]),
      .in_i     (in_i[gi]),
      .fft_A_r  (a_r[gi]),
      .fft_A_i  (a_i[gi]),
      .fft_W_r  (w_r[gi]),
      .fft_W_i  (w_i[gi]),
      .fft_C_r  (c_r_w),
      .fft_C_i  (c_i_w),
      .fft_EX   (ex_w),
      .out_valid(out_valid[gi]),
      .out_ready(out_ready[gi]),
      .out_r    (out_r[gi]),
      .out_i    (out_i[gi]),
      .out_idx  (out_idx[gi]),
      .out_last (out_last[gi]),
      .out_ex   (out_ex[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus utilities ----------------
  function automatic int cc_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'($urandom_range(137, 117)), 23'($urandom)};
  endfunction

  task automatic set_random_frame();
    for (int j = 0; j < 8; j++) begin
      frame_r[j] = rand_float();
      frame_i[j] = rand_float();
    end
  endtask

  task automatic model_frame();
    logic [7:0][31:0] pr, pi;
    for (int j = 0; j < 8; j++) begin
      pr[j] = frame_r[j];
      pi[j] = frame_i[j];
    end
    fft_model(pr, pi, exp_r_p, exp_i_p, exp_ex);
  endtask

  // Pushes frame_* into DUT d and collects stop_after results. Called at
  // posedge+1; returns at posedge+1 after the last collected accept edge.
  task automatic run_frame(input int d, input bit gapped, input bit bp, input int stop_after);
    int               n_in, oc, since8;
    bit               iv, orr, ia, oa, prev_hold;
    logic [31:0]      pr, pi;
    logic [2:0]       pidx;
    logic             pex;
    logic [7:0][31:0] fr, fi;
    for (int j = 0; j < 8; j++) begin
      fr[j] = frame_r[j];
      fi[j] = frame_i[j];
    end
    n_in = 0; oc = 0; since8 = -1; prev_hold = 0;
    pr = '0; pi = '0; pidx = '0; pex = 1'b0;
    n_got = 0; lat = -1; cycles = 0; hold_err = 0; early_err = 0; timeout = 0;
    while (n_got < stop_after) begin
      if (cycles > 400) begin
        timeout = 1;
        break;
      end
      if (out_valid[d] && n_in < 8) early_err++;
      if (n_in == 8 && (a_r[d] !== fr || a_i[d] !== fi)) hold_err++;
      if (prev_hold && out_valid[d] &&
          (out_r[d] !== pr || out_i[d] !== pi || out_idx[d] !== pidx || out_ex[d] !== pex))
        hold_err++;
      if (n_in < 8) iv = gapped ? ($urandom_range(2, 0) != 0) : 1'b1;
      else          iv = gapped ? 1'($urandom) : 1'b0;
      in_valid[d] = iv;
      if (n_in < 8 && iv) begin
        in_r[d] = frame_r[n_in];
        in_i[d] = frame_i[n_in];
      end else begin
        in_r[d] = $urandom;
        in_i[d] = $urandom;
      end
      if (out_valid[d]) begin
        orr = bp ? bp_pat[oc % 6] : 1'b1;
        oc++;
      end else begin
        orr = bp ? 1'($urandom) : 1'b1;
      end
      out_ready[d] = orr;
      ia = iv && in_ready[d];
      oa = out_valid[d] && orr;
      if (oa) begin
        got_r[n_got]    = out_r[d];
        got_i[n_got]    = out_i[d];
        got_idx[n_got]  = out_idx[d];
        got_last[n_got] = out_last[d];
        got_ex[n_got]   = out_ex[d];
        $display("dut%0d result idx=%0d r=%h i=%h last=%b ex=%b",
                 d, out_idx[d], out_r[d], out_i[d], out_last[d], out_ex[d]);
        n_got++;
      end
      prev_hold = out_valid[d] && !orr;
      pr = out_r[d]; pi = out_i[d]; pidx = out_idx[d]; pex = out_ex[d];
      @(posedge clk);
      #1;
      cycles++;
      if (ia) begin
        n_in++;
        if (n_in == 8) since8 = 0;
      end else if (since8 >= 0 && lat < 0) begin
        since8++;
      end
      if (since8 >= 0 && lat < 0 && out_valid[d]) lat = since8;
    end
    ready_after  = in_ready[d];
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++; if (in_ready[d] !== 1'b1)  begin miscompares++; $display("FAIL rst_in_ready dut%0d got %b want 1", d, in_ready[d]); end
      vectors++; if (out_valid[d] !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid dut%0d got %b want 0", d, out_valid[d]); end
      vectors++; if (out_last[d] !== 1'b0)  begin miscompares++; $display("FAIL rst_out_last dut%0d got %b want 0", d, out_last[d]); end
      vectors++; if (out_ex[d] !== 1'b0)    begin miscompares++; $display("FAIL rst_out_ex dut%0d got %b want 0", d, out_ex[d]); end
      vectors++; if (out_idx[d] !== 3'd0)   begin miscompares++; $display("FAIL rst_out_idx dut%0d got %0d want 0", d, out_idx[d]); end
      vectors++; if (out_r[d] !== 32'd0 || out_i[d] !== 32'd0) begin miscompares++; $display("FAIL rst_out_data dut%0d got %h/%h want 0/0", d, out_r[d], out_i[d]); end
      vectors++; if (a_r[d] !== '0 || a_i[d] !== '0) begin miscompares++; $display("FAIL rst_frame_regs dut%0d got nonzero want 0", d); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_twiddle();
    logic [3:0][31:0] er, ei;
    er = {32'hBF3504F3, 32'h00000000, 32'h3F3504F3, 32'h3F800000};
    ei = {32'hBF3504F3, 32'hBF800000, 32'hBF3504F3, 32'h00000000};
    for (int d = 0; d < 2; d++) begin
      vectors++; if (w_r[d] !== er) begin miscompares++; $display("FAIL twiddle_r dut%0d got %h want %h", d, w_r[d], er); end
      vectors++; if (w_i[d] !== ei) begin miscompares++; $display("FAIL twiddle_i dut%0d got %h want %h", d, w_i[d], ei); end
    end
  endtask

  task automatic test_impulse();
    for (int j = 0; j < 8; j++) begin
      frame_r[j] = (j == 0) ? 32'h3F800000 : 32'h0;
      frame_i[j] = 32'h0;
    end
    run_frame(0, 1'b0, 1'b0, 8);
    vectors++; if (n_got !== 8) begin miscompares++; $display("FAIL impulse_count got %0d want 8", n_got); end
    vectors++; if (lat !== 1)   begin miscompares++; $display("FAIL impulse_latency got %0d want 1", lat); end
    for (int j = 0; j < n_got; j++) begin
      vectors++; if (got_r[j] !== 32'h3F800000 || got_i[j] !== 32'h0) begin miscompares++; $display("FAIL impulse_data j%0d got %h/%h want 3f800000/00000000", j, got_r[j], got_i[j]); end
      vectors++; if (got_idx[j] !== 3'(j)) begin miscompares++; $display("FAIL impulse_idx j%0d got %0d want %0d", j, got_idx[j], j); end
      vectors++; if (got_last[j] !== (j == 7)) begin miscompares++; $display("FAIL impulse_last j%0d got %b want %b", j, got_last[j], j == 7); end
      vectors++; if (got_ex[j] !== 1'b0) begin miscompares++; $display("FAIL impulse_ex j%0d got %b want 0", j, got_ex[j]); end
    end
  endtask

  task automatic test_dc();
    real vr, vi;
    for (int j = 0; j < 8; j++) begin
      frame_r[j] = 32'h3F800000;
      frame_i[j] = 32'h0;
    end
    run_frame(0, 1'b0, 1'b0, 8);
    vectors++; if (n_got !== 8) begin miscompares++; $display("FAIL dc_count got %0d want 8", n_got); end
    vectors++; if (got_r[0] !== 32'h41000000 || got_i[0] !== 32'h0) begin miscompares++; $display("FAIL dc_bin0 got %h/%h want 41000000/00000000", got_r[0], got_i[0]); end
    for (int j = 1; j < n_got; j++) begin
      vr = f2r(got_r[j]); if (vr < 0.0) vr = -vr;
      vi = f2r(got_i[j]); if (vi < 0.0) vi = -vi;
      vectors++; if (!(vr < 1e-6) || !(vi < 1e-6)) begin miscompares++; $display("FAIL dc_bin j%0d got %h/%h want |x|<1e-6", j, got_r[j], got_i[j]); end
      vectors++; if (got_idx[j] !== 3'(j)) begin miscompares++; $display("FAIL dc_idx j%0d got %0d want %0d", j, got_idx[j], j); end
    end
  endtask

  task automatic test_backpressure();
    for (int d = 0; d < 2; d++) begin
      for (int rep = 0; rep < 3; rep++) begin
        set_random_frame();
        model_frame();
        run_frame(d, 1'b1, 1'b1, 8);
        vectors++; if (timeout || n_got !== 8) begin miscompares++; $display("FAIL bp_count dut%0d got %0d want 8 (timeout=%0b)", d, n_got, timeout); end
        vectors++; if (lat !== cc_of(d)) begin miscompares++; $display("FAIL bp_latency dut%0d got %0d want %0d", d, lat, cc_of(d)); end
        vectors++; if (hold_err !== 0) begin miscompares++; $display("FAIL bp_hold dut%0d got %0d unstable cycles want 0", d, hold_err); end
        vectors++; if (early_err !== 0) begin miscompares++; $display("FAIL bp_early dut%0d got %0d early valid cycles want 0", d, early_err); end
        for (int j = 0; j < n_got; j++) begin
          vectors++; if (got_r[j] !== exp_r_p[j] || got_i[j] !== exp_i_p[j]) begin miscompares++; $display("FAIL bp_data dut%0d j%0d got %h/%h want %h/%h", d, j, got_r[j], got_i[j], exp_r_p[j], exp_i_p[j]); end
          vectors++; if (got_idx[j] !== 3'(j) || got_last[j] !== (j == 7)) begin miscompares++; $display("FAIL bp_idx dut%0d j%0d got idx %0d last %b want %0d/%b", d, j, got_idx[j], got_last[j], j, j == 7); end
          vectors++; if (got_ex[j] !== exp_ex) begin miscompares++; $display("FAIL bp_ex dut%0d j%0d got %b want %b", d, j, got_ex[j], exp_ex); end
        end
      end
    end
  endtask

  task automatic test_exception();
    for (int f = 0; f < 2; f++) begin
      set_random_frame();
      if (f == 0) begin
        frame_r[2] = 32'h7F800000;
        frame_i[2] = 32'h0;
      end
      model_frame();
      run_frame(0, 1'b0, 1'b1, 8);
      vectors++; if (n_got !== 8) begin miscompares++; $display("FAIL ex_count f%0d got %0d want 8", f, n_got); end
      for (int j = 0; j < n_got; j++) begin
        vectors++; if (got_ex[j] !== (f == 0)) begin miscompares++; $display("FAIL ex_flag f%0d j%0d got %b want %b", f, j, got_ex[j], f == 0); end
        vectors++; if (got_r[j] !== exp_r_p[j] || got_i[j] !== exp_i_p[j]) begin miscompares++; $display("FAIL ex_data f%0d j%0d got %h/%h want %h/%h", f, j, got_r[j], got_i[j], exp_r_p[j], exp_i_p[j]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int  cyc1;
    bit  rdy1;
    for (int d = 0; d < 2; d++) begin
      set_random_frame();
      model_frame();
      run_frame(d, 1'b0, 1'b0, 8);
      cyc1 = cycles;
      rdy1 = ready_after;
      for (int j = 0; j < n_got; j++) begin
        vectors++; if (got_r[j] !== exp_r_p[j] || got_i[j] !== exp_i_p[j]) begin miscompares++; $display("FAIL b2b_data1 dut%0d j%0d got %h/%h want %h/%h", d, j, got_r[j], got_i[j], exp_r_p[j], exp_i_p[j]); end
      end
      vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL b2b_ready dut%0d got %b want 1", d, rdy1); end
      set_random_frame();
      model_frame();
      run_frame(d, 1'b0, 1'b0, 8);
      vectors++; if (n_got !== 8) begin miscompares++; $display("FAIL b2b_count dut%0d got %0d want 8", d, n_got); end
      vectors++; if (cyc1 + cycles !== 2 * (16 + cc_of(d))) begin miscompares++; $display("FAIL b2b_cycles dut%0d got %0d want %0d", d, cyc1 + cycles, 2 * (16 + cc_of(d))); end
      for (int j = 0; j < n_got; j++) begin
        vectors++; if (got_r[j] !== exp_r_p[j] || got_i[j] !== exp_i_p[j] || got_idx[j] !== 3'(j)) begin miscompares++; $display("FAIL b2b_data2 dut%0d j%0d got %h/%h idx %0d want %h/%h idx %0d", d, j, got_r[j], got_i[j], got_idx[j], exp_r_p[j], exp_i_p[j], j); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    set_random_frame();
    run_frame(0, 1'b0, 1'b0, 3);
    vectors++; if (out_valid[0] !== 1'b1 || out_idx[0] !== 3'd3) begin miscompares++; $display("FAIL mid_pre dut0 got valid %b idx %0d want 1/3", out_valid[0], out_idx[0]); end
    rst_n = 1'b0;
    #1;
    vectors++; if (in_ready[0] !== 1'b1)  begin miscompares++; $display("FAIL mid_in_ready got %b want 1", in_ready[0]); end
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid got %b want 0", out_valid[0]); end
    vectors++; if (out_idx[0] !== 3'd0)   begin miscompares++; $display("FAIL mid_out_idx got %0d want 0", out_idx[0]); end
    vectors++; if (out_r[0] !== 32'd0 || a_r[0] !== '0) begin miscompares++; $display("FAIL mid_clear got out_r %h want 0 and frame cleared", out_r[0]); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_random_frame();
    model_frame();
    run_frame(0, 1'b1, 1'b0, 8);
    vectors++; if (early_err !== 0) begin miscompares++; $display("FAIL mid_early got %0d early valid cycles want 0", early_err); end
    vectors++; if (n_got !== 8 || lat !== 1) begin miscompares++; $display("FAIL mid_frame got count %0d latency %0d want 8/1", n_got, lat); end
    for (int j = 0; j < n_got; j++) begin
      vectors++; if (got_r[j] !== exp_r_p[j] || got_i[j] !== exp_i_p[j] || got_idx[j] !== 3'(j)) begin miscompares++; $display("FAIL mid_data j%0d got %h/%h idx %0d want %h/%h idx %0d", j, got_r[j], got_i[j], got_idx[j], exp_r_p[j], exp_i_p[j], j); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bp_pat      = 6'b101001;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_r[d]      = '0;
      in_i[d]      = '0;
    end
    test_reset();
    test_twiddle();
    test_impulse();
    test_dc();
    test_backpressure();
    test_exception();
    test_back_to_back();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
